// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMStart = 3'd1,
    StMWait  = 3'd2,
    StDStart = 3'd3,
    StDWait  = 3'd4,
    StWrite  = 3'd5,
    StFin    = 3'd6,
    StErr    = 3'd7
  } state_e;

  localparam logic OP_MULT       = 1'b0;
  localparam logic OP_DIV        = 1'b1;
  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV  = 1'b1;

  function automatic logic is_start_state(state_e s);
    return (s == StMStart) || (s == StDStart);
  endfunction

  function automatic logic is_wait_state(state_e s);
    return (s == StMWait) || (s == StDWait);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Watchdog counter bounding how long the sequencer waits for a unit's done flag.
module muldiv_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == LIMIT);
  assign o_expire   = i_enable & w_at_limit;

  // Saturates at the limit so a late fim can never see a wrapped count.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider: start pulse, wait for done, load HI/LO or raise
// an exception. All outputs are registered and decoded from the next state.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_op_valid,
  input  logic i_op_kind,
  input  logic i_mult_fim,
  input  logic i_div_fim,
  input  logic i_div_zero,
  output logic o_mult_start,
  output logic o_div_start,
  output logic o_hi_write,
  output logic o_lo_write,
  output logic o_hilo_sel,
  output logic o_busy,
  output logic o_done,
  output logic o_exc_div0,
  output logic o_exc_tmo
);

  state_e r_state, w_state_d;
  logic   r_op, w_op_d;
  logic   r_err_div0, w_err_div0_d;
  logic   w_expire;

  logic r_mult_start, r_div_start, r_hi_write, r_lo_write, r_hilo_sel;
  logic r_busy, r_done, r_exc_div0, r_exc_tmo;
  logic w_mult_start_d, w_div_start_d, w_write_d, w_hilo_sel_d;
  logic w_busy_d, w_done_d, w_exc_div0_d, w_exc_tmo_d;

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (is_start_state(r_state)),
    .i_enable(is_wait_state(r_state)),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_err_div0_d = r_err_div0;
    case (r_state)
      StIdle: begin
        if (i_op_valid) begin
          w_op_d    = i_op_kind;
          w_state_d = (i_op_kind == OP_DIV) ? StDStart : StMStart;
        end
      end
      StMStart: w_state_d = StMWait;
      StDStart: w_state_d = StDWait;
      StMWait: begin
        if (i_mult_fim) begin
          w_state_d = StWrite;
        end else if (w_expire) begin
          w_state_d    = StErr;
          w_err_div0_d = 1'b0;
        end
      end
      StDWait: begin
        // Divide-by-zero outranks both a simultaneous done and the watchdog.
        if (i_div_zero) begin
          w_state_d    = StErr;
          w_err_div0_d = 1'b1;
        end else if (i_div_fim) begin
          w_state_d = StWrite;
        end else if (w_expire) begin
          w_state_d    = StErr;
          w_err_div0_d = 1'b0;
        end
      end
      StWrite: w_state_d = StFin;
      StFin:   w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_mult_start_d = (w_state_d == StMStart);
    w_div_start_d  = (w_state_d == StDStart);
    w_write_d      = (w_state_d == StWrite);
    w_hilo_sel_d   = HILO_SEL_MULT;
    if ((w_state_d == StWrite || w_state_d == StFin) && w_op_d == OP_DIV) begin
      w_hilo_sel_d = HILO_SEL_DIV;
    end
    w_busy_d     = (w_state_d != StIdle);
    w_done_d     = (w_state_d == StFin);
    w_exc_div0_d = (w_state_d == StErr) && w_err_div0_d;
    w_exc_tmo_d  = (w_state_d == StErr) && !w_err_div0_d;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_op         <= OP_MULT;
      r_err_div0   <= 1'b0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
      r_hi_write   <= 1'b0;
      r_lo_write   <= 1'b0;
      r_hilo_sel   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_exc_div0   <= 1'b0;
      r_exc_tmo    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_op         <= w_op_d;
      r_err_div0   <= w_err_div0_d;
      r_mult_start <= w_mult_start_d;
      r_div_start  <= w_div_start_d;
      r_hi_write   <= w_write_d;
      r_lo_write   <= w_write_d;
      r_hilo_sel   <= w_hilo_sel_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_exc_div0   <= w_exc_div0_d;
      r_exc_tmo    <= w_exc_tmo_d;
    end
  end

  assign o_mult_start = r_mult_start;
  assign o_div_start  = r_div_start;
  assign o_hi_write   = r_hi_write;
  assign o_lo_write   = r_lo_write;
  assign o_hilo_sel   = r_hilo_sel;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_exc_div0   = r_exc_div0;
  assign o_exc_tmo    = r_exc_tmo;

endmodule
